// File: rtl/pipelined_adder_pkg.sv
// Shared helpers for the pipelined adder: chunk sizing and parameter legality.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package pipelined_adder_pkg;

    // Width of the carry chunk handled by each pipeline stage.
    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    // Legal configurations: at least one bit, at least one stage, and the
    // operand width must split evenly into stage chunks.
    function automatic bit params_ok(input int width, input int stages);
        return (width >= 1) && (stages >= 1) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_stage.sv
// One CHUNK-wide slice of the carry chain: registered sum chunk, carry-out and valid bit.
// Latency: 1 cycle (result registered on the edge where the stage advances).
// Backpressure: holds all state while i_adv is low; only loads data when a valid beat enters.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_adv           stage advances this cycle (valid bit takes i_vld)
//   i_vld           incoming beat is valid
//   i_a, i_b, i_cin chunk operands and carry from the previous stage
//   o_vld           stage holds a valid beat
//   o_sum, o_cout   registered chunk sum and carry-out
//   o_ovf           registered signed overflow (only meaningful in the MSB stage, else 0)
module adder_stage
    import pipelined_adder_pkg::*;
#(
    parameter int CHUNK = 8,
    parameter bit LAST  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_adv,
    input  logic             i_vld,
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic             o_vld,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    logic [CHUNK:0]   w_full;
    logic             w_load;
    logic             r_vld;
    logic [CHUNK-1:0] r_sum;
    logic             r_cout;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
    // Data only moves when a real beat enters, so a stalled or idle stage keeps
    // its last result stable.
    assign w_load = i_adv && i_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld  <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            if (i_adv) begin
                r_vld <= i_vld;
            end
            if (w_load) begin
                r_sum  <= w_full[CHUNK-1:0];
                r_cout <= w_full[CHUNK];
            end
        end
    end

    assign o_vld  = r_vld;
    assign o_sum  = r_sum;
    assign o_cout = r_cout;

    if (LAST) begin : g_ovf
        logic w_c_msb;
        logic r_ovf;

        // Carry into the MSB recovered from the MSB sum bit and its operands.
        assign w_c_msb = i_a[CHUNK-1] ^ i_b[CHUNK-1] ^ w_full[CHUNK-1];

        always_ff @(posedge clk) begin
            if (rst) begin
                r_ovf <= 1'b0;
            end else if (w_load) begin
                r_ovf <= w_c_msb ^ w_full[CHUNK];
            end
        end

        assign o_ovf = r_ovf;
    end else begin : g_no_ovf
        assign o_ovf = 1'b0;
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined two's-complement adder/subtractor with the carry chain cut into STAGES chunks.
// Latency: STAGES cycles from acceptance to out_valid; 1 beat/cycle when unstalled.
// Backpressure: valid/ready; per-stage valid bits collapse bubbles, in_ready is combinational from out_ready.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      operand handshake (a, b, cin, sub)
//   sub                      0: a+b+cin, 1: a-b-cin (cin acts as borrow-in)
//   out_valid / out_ready    result handshake (sum, cout, ovf)
//   cout                     raw carry out of the MSB (for subtract, 1 = no borrow)
//   ovf                      signed overflow
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be >= 1 and a multiple of STAGES");
    end

    // Per-boundary buses, zero-extended to WIDTH:
    //   w_opa/w_opb[k] : operand chunks k..STAGES-1 feeding stage k, chunk k in the LSBs
    //   w_acc[k]       : finished sum chunks 0..k held after stage k
    logic [WIDTH-1:0]  w_opa [STAGES];
    logic [WIDTH-1:0]  w_opb [STAGES];
    logic [WIDTH-1:0]  w_acc [STAGES];
    logic [STAGES:0]   w_carry;
    logic [STAGES-1:0] w_v;
    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] w_ovf;

    // Subtraction folds into addition: a - b - cin == a + ~b + ~cin.
    assign w_opa[0]   = a;
    assign w_opb[0]   = sub ? ~b : b;
    assign w_carry[0] = sub ? ~cin : cin;

    // Advance chain: a stage moves if it is empty or its successor moves, so
    // empty slots are filled even while the output is stalled.
    always_comb begin
        w_adv = '0;
        w_adv[STAGES-1] = !w_v[STAGES-1] || out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_adv[k] = !w_v[k] || w_adv[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        logic             w_vld_in;
        logic [CHUNK-1:0] w_sum_chunk;

        if (k == 0) begin : g_src_in
            assign w_vld_in = in_valid;
        end else begin : g_src_prev
            assign w_vld_in = w_v[k-1];
        end

        adder_stage #(
            .CHUNK (CHUNK),
            .LAST  (k == STAGES - 1)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .i_adv  (w_adv[k]),
            .i_vld  (w_vld_in),
            .i_a    (w_opa[k][CHUNK-1:0]),
            .i_b    (w_opb[k][CHUNK-1:0]),
            .i_cin  (w_carry[k]),
            .o_vld  (w_v[k]),
            .o_sum  (w_sum_chunk),
            .o_cout (w_carry[k+1]),
            .o_ovf  (w_ovf[k])
        );

        // Operand chunks not yet consumed travel alongside the carry.
        if (k < STAGES - 1) begin : g_pass_op
            localparam int HI_W = (STAGES - 1 - k) * CHUNK;
            logic [HI_W-1:0] r_a_hi;
            logic [HI_W-1:0] r_b_hi;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a_hi <= '0;
                    r_b_hi <= '0;
                end else if (w_adv[k] && w_vld_in) begin
                    r_a_hi <= w_opa[k][CHUNK +: HI_W];
                    r_b_hi <= w_opb[k][CHUNK +: HI_W];
                end
            end

            assign w_opa[k+1] = WIDTH'(r_a_hi);
            assign w_opb[k+1] = WIDTH'(r_b_hi);
        end

        // Lower sum chunks already computed ride along until the last stage.
        if (k == 0) begin : g_acc_first
            assign w_acc[0] = WIDTH'(w_sum_chunk);
        end else begin : g_acc_next
            localparam int LO_W = k * CHUNK;
            logic [LO_W-1:0] r_lo;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_lo <= '0;
                end else if (w_adv[k] && w_vld_in) begin
                    r_lo <= w_acc[k-1][LO_W-1:0];
                end
            end

            assign w_acc[k] = WIDTH'({w_sum_chunk, r_lo});
        end
    end

    assign in_ready  = w_adv[0];
    assign out_valid = w_v[STAGES-1];
    assign sum       = w_acc[STAGES-1];
    assign cout      = w_carry[STAGES];
    // Only the MSB stage drives a non-zero overflow bit.
    assign ovf       = |w_ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: three 8-bit instances (STAGES = 4, 1, 8), one exercised at a time.
// Latency: checked against STAGES for beats entering an empty pipe.
// Backpressure: out_ready held low / randomised; scoreboard checks order, loss and stability.
module tb_pipelined_adder;

    localparam int NI = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      a   = '0;
    logic [7:0]      b   = '0;
    logic            cin = 1'b0;
    logic            sub = 1'b0;
    logic [NI-1:0]   in_valid  = '0;
    logic [NI-1:0]   out_ready = '1;
    logic [NI-1:0]   in_ready;
    logic [NI-1:0]   out_valid;
    logic [NI-1:0]   cout_o;
    logic [NI-1:0]   ovf_o;
    logic [7:0]      sum_o [NI];

    pipelined_adder #(.WIDTH(8), .STAGES(4)) u_s4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .sum(sum_o[0]), .cout(cout_o[0]), .ovf(ovf_o[0]));

    pipelined_adder #(.WIDTH(8), .STAGES(1)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .sum(sum_o[1]), .cout(cout_o[1]), .ovf(ovf_o[1]));

    pipelined_adder #(.WIDTH(8), .STAGES(8)) u_s8 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .sum(sum_o[2]), .cout(cout_o[2]), .ovf(ovf_o[2]));

    always #5 clk = ~clk;

    typedef struct {
        int         inst;
        logic [9:0] res;     // {sum, cout, ovf}
        int         t_push;
        bit         chk_lat;
    } exp_t;

    exp_t       sb_q[$];
    int         fire_t[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         pcyc    = 0;
    int         sel     = 0;
    bit         rand_rdy = 1'b0;
    logic [NI-1:0] prev_ov  = '0;
    logic [NI-1:0] stall_pv = '0;
    logic [9:0] held [NI];

    function automatic int lat_of(input int i);
        return (i == 0) ? 4 : (i == 1) ? 1 : 8;
    endfunction

    // Reference: plain integer arithmetic on a + B' + c0.
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                         input logic ci, input logic sb);
        int bv, c0, tot, sx, sy, st;
        logic [9:0] r;
        bv  = sb ? 255 - int'(y) : int'(y);
        c0  = ((sb ? !ci : ci) == 1'b1) ? 1 : 0;
        tot = int'(x) + bv + c0;
        sx  = (int'(x) >= 128) ? int'(x) - 256 : int'(x);
        sy  = (bv >= 128) ? bv - 256 : bv;
        st  = sx + sy + c0;
        r[9:2] = tot[7:0];
        r[1]   = (tot >= 256);
        r[0]   = (st > 127) || (st < -128);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) pcyc++;

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready[sel] = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops and compares every output transfer, checks hold stability
    // under stall and first-result latency on an empty pipe.
    always @(negedge clk) begin
        if (rst) begin
            prev_ov  = '0;
            stall_pv = '0;
        end else begin
            for (int i = 0; i < NI; i++) begin
                logic [9:0] cur;
                exp_t e;
                cur = {sum_o[i], cout_o[i], ovf_o[i]};
                if (out_valid[i] && !prev_ov[i] && sb_q.size() > 0 &&
                    sb_q[0].inst == i && sb_q[0].chk_lat)
                    chk($sformatf("latency[%0d]", i), pcyc - sb_q[0].t_push, lat_of(i));
                if (out_valid[i] && !out_ready[i]) begin
                    if (stall_pv[i]) chk($sformatf("stall_hold[%0d]", i), cur, held[i]);
                    stall_pv[i] = 1'b1;
                    held[i] = cur;
                end else begin
                    stall_pv[i] = 1'b0;
                end
                if (out_valid[i] && out_ready[i]) begin
                    if (sb_q.size() == 0 || sb_q[0].inst != i) begin
                        chk($sformatf("unexpected_out[%0d]", i), 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk($sformatf("result[%0d]", i), cur, e.res);
                        if (i == sel) fire_t.push_back(pcyc);
                    end
                end
                prev_ov[i] = out_valid[i];
            end
        end
    end

    // All flow tasks start and end at posedge+#1.
    task automatic send(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                        input logic ts, input bit has_exp, input logic [9:0] ex,
                        input bit lat, output int waits);
        exp_t e;
        bit   done;
        waits = 0;
        done  = 1'b0;
        a = ta; b = tb_v; cin = tc; sub = ts;
        in_valid[sel] = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready[sel]) begin
                e.inst    = sel;
                e.res     = has_exp ? ex : model(ta, tb_v, tc, ts);
                e.t_push  = pcyc;
                e.chk_lat = lat;
                sb_q.push_back(e);
                done = 1'b1;
            end else if (waits > 200) begin
                chk("send_timeout", 1, 0);
                done = 1'b1;
            end else begin
                waits++;
            end
            @(posedge clk); #1;
        end
        in_valid[sel] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", sb_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic send_rand(input int cnt, output int waits_total);
        int w;
        waits_total = 0;
        for (int k = 0; k < cnt; k++) begin
            send(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0, '0, 1'b0, w);
            waits_total += w;
        end
    endtask

    initial begin
        int w, acc, hi_cnt;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("reset_state[%0d]", i),
                {out_valid[i], sum_o[i], cout_o[i], ovf_o[i], in_ready[i]}, 12'h001);
        end
        @(posedge clk); #1;

        // Directed vectors on each depth, entering an empty pipe.
        for (int i = 0; i < NI; i++) begin
            sel = i;
            send(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, {8'h00, 1'b1, 1'b0}, 1'b1, w); drain();
            send(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, {8'h80, 1'b0, 1'b1}, 1'b1, w); drain();
            send(8'h05, 8'h07, 1'b0, 1'b1, 1'b1, {8'hFE, 1'b0, 1'b0}, 1'b1, w); drain();
        end

        // Back-to-back stream with out_ready high on STAGES=4.
        sel = 0;
        fire_t.delete();
        send_rand(16, w);
        chk("stream_no_wait", w, 0);
        drain();
        chk("stream_out_count", fire_t.size(), 16);
        if (fire_t.size() == 16) chk("stream_out_span", fire_t[15] - fire_t[0], 15);

        // Full stall: exactly STAGES beats accepted, then in_ready drops.
        out_ready[0] = 1'b0;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            exp_t e;
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            in_valid[0] = 1'b1;
            @(negedge clk);
            if (in_ready[0]) begin
                e.inst = 0; e.res = model(a, b, cin, sub); e.t_push = pcyc; e.chk_lat = 1'b0;
                sb_q.push_back(e);
                acc++;
            end
            @(posedge clk); #1;
        end
        in_valid[0] = 1'b0;
        chk("stall_accepted", acc, 4);
        @(negedge clk);
        chk("stall_in_ready", in_ready[0], 0);
        @(posedge clk); #1;
        out_ready[0] = 1'b1;
        drain();

        // Reset with three beats in flight.
        send_rand(3, w);
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_flush_state", {out_valid[0], sum_o[0], in_ready[0]}, 10'h001);
        hi_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (out_valid[0]) hi_cnt++;
        end
        chk("rst_no_stale", hi_cnt, 0);
        @(posedge clk); #1;

        // Random traffic with random out_ready on every depth.
        for (int i = 0; i < NI; i++) begin
            sel = i;
            rand_rdy = 1'b1;
            send_rand(30, w);
            rand_rdy = 1'b0;
            #1 out_ready[i] = 1'b1;
            @(posedge clk); #1;
            drain();
        end

        chk("final_queue_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined two's-complement adder/subtractor: the next generation of the single-cycle 8-bit ripple adder. The carry chain is split into STAGES register-separated chunks so WIDTH can grow without lengthening the critical path. A valid/ready handshake with per-stage bubble collapsing provides backpressure. It sits between operand producers and any consumer that can stall.

## Interface
- WIDTH, 32, operand/result width in bits; must be ≥ 1.
- STAGES, 4, number of pipeline stages (carry chunks); WIDTH % STAGES must equal 0. CHUNK = WIDTH/STAGES.
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset is synchronous and active-high.
- in_valid  in  1  operand beat present.
- in_ready  out  1  stage 0 can accept this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) / borrow-in (sub).
- sub  in  1  0: a+b+cin; 1: a−b−cin.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  raw carry out of MSB (for sub: 1 = no borrow).
- ovf  out  1  signed overflow.

## Operation
- Effective operand B' = sub ? ~b : b; effective carry c0 = sub ? ~cin : cin. Result = a + B' + c0.
- Stage k (0..STAGES−1) adds chunk k of a and B' with the carry registered from stage k−1 (stage 0 uses c0).
- Upper operand chunks are carried forward unchanged through the stage registers until consumed. Completed lower sum chunks are carried forward until the final stage.
- ovf = carry into MSB XOR carry out of MSB, computed in the last stage.
- Each stage holds a valid bit v[k]. Stage k advances when v[k]=0 or stage k+1 advances; the last stage advances when out_valid=0 or out_ready=1.
- in_ready = stage 0 may load = !v[0] || stage 1 advances. Beats transfer on in_valid && in_ready. Output beats transfer on out_valid && out_ready.
- Bubbles collapse: an empty stage accepts from its predecessor even if downstream is stalled.
- Data registers load only when their stage loads. A stalled stage holds its value, so sum/cout/ovf stay stable while out_valid && !out_ready.
- No state machine beyond per-stage valid bits; the pipeline is fully streaming, one result per cycle when unstalled.

## Timing
- Latency: a beat accepted at edge n is presented (out_valid=1) after edge n+STAGES−1, so STAGES cycles from acceptance to visible result with no stall. For STAGES=1 this is a registered single-cycle adder.
- Throughput: 1 beat/cycle with out_ready held high.
- in_ready is combinational from out_ready through the valid chain. No combinational path from in_valid to out_valid.
- Reset (sync, asserted at an edge): all v[k]=0, out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 from the first cycle after reset while out_ready has any value.
- Reset mid-operation discards all in-flight beats; none reappear afterwards.
- Simultaneous output pop and input push at full occupancy: both transfer, occupancy unchanged.
- Order is strictly preserved; no beat is dropped or duplicated under any out_ready pattern.

## Structure
- Package pipelined_adder_pkg: helper function for CHUNK, and an elaboration check that WIDTH % STAGES == 0 and WIDTH ≥ 1.
- Sub-module adder_stage: one CHUNK-wide add with carry-in/out, valid bit, and load enable. Instantiated STAGES times by a generate loop; the last instance also produces ovf.
- Pass-through operand and sum-chunk registers live in the parent, sized per stage index.

## Test plan
- WIDTH=8, STAGES=4: a=0xFF, b=0x01, cin=0, sub=0 -> sum=0x00, cout=1, ovf=0, out_valid exactly 4 cycles after acceptance.
- a=0x7F, b=0x01, add -> sum=0x80, cout=0, ovf=1. a=0x05, b=0x07, cin=0, sub=1 -> sum=0xFE, cout=0, ovf=0.
- Stream 16 random beats back-to-back with out_ready=1 -> 16 results in order, one per cycle, matching the reference model a+B'+c0.
- Hold out_ready=0 while streaming -> in_ready drops after exactly 4 accepted beats, output stays stable. Release out_ready -> all beats drain in order, no loss or duplication.
- Assert rst with 3 beats in flight -> next cycle out_valid=0, sum=0, in_ready=1. No stale beat emerges afterwards.
- STAGES=1, WIDTH=8 and STAGES=8, WIDTH=8: same vectors as the first two scenarios -> identical results with latency 1 and 8 respectively.
